// File: rtl/aes_result_fifo_if.sv
// Wishbone slave bundle for the AES result FIFO window.
// The master modport is the bus/CPU side; the slave modport is the FIFO.
`timescale 1ns/1ps
interface aes_result_fifo_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/aes_result_fifo.sv
// Result FIFO behind the AES core: queues 128-bit ciphertexts, read over Wishbone.
// Optional interrupt output and mask bit are enabled with AES_RESULT_IRQ_EN.
`timescale 1ns/1ps
module aes_result_fifo #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0030,
  parameter int          DEPTH        = 4,
  parameter int          CNT_W        = 5
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  aes_result_fifo_if.slave    wb,
  input  logic                ct_valid_i,
  input  logic [127:0]        ct_i,
  output logic                full_o
`ifdef AES_RESULT_IRQ_EN
  ,
  output logic                irq_o
`endif
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [2:0] W_STATUS = 3'd4;
  localparam logic [2:0] W_CTRL   = 3'd5;

  // Handshake: a transfer is accepted on the edge where cyc&stb are high,
  // ack is low and the address hits the window; ack then pulses for one
  // cycle with registered read data. The master must hold its request until ack.
  logic [31:0]      off;
  logic             in_window;
  logic [2:0]       word;
  logic             accept;
  logic             ctrl_wr;
  logic             pop_req;
  logic             ovf_clr;

  logic [127:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             ovf_q;
  logic             ovf_nxt;
  logic             ovf_set;
  logic             full_q;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  logic             ack_q;
  logic [31:0]      dat_q;
  logic [31:0]      rdata;
  logic [31:0]      status;
  logic [127:0]     head;
  logic             unused_dat;

  assign off       = wb.wbs_adr_i - BASE_ADDRESS;
  assign in_window = (off < 32'd24);
  assign word      = off[4:2];
  assign accept    = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q & in_window;
  assign ctrl_wr   = accept & wb.wbs_we_i & (word == W_CTRL);
  assign pop_req   = ctrl_wr & wb.wbs_dat_i[0];
  assign ovf_clr   = ctrl_wr & wb.wbs_dat_i[1];
  assign unused_dat = ^wb.wbs_dat_i[31:2];

  assign empty     = (count_q == '0);
  // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
  assign do_pop    = pop_req & ~empty;
  assign do_push   = ct_valid_i & (~full_q | do_pop);
  assign ovf_set   = ct_valid_i & full_q & ~do_pop;
  assign ovf_nxt   = ovf_set | (ovf_q & ~ovf_clr);
  assign count_nxt = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  // Storage needs no reset: emptiness gates every read of it.
  always_ff @(posedge wb_clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= ct_i;
    end
  end

  assign head = mem[rd_ptr_q];

`ifdef AES_RESULT_IRQ_EN
  logic irq_en_q;
  logic irq_en_nxt;
  logic irq_q;

  // CTRL bit3 set means "mask off"; any CTRL write without it re-enables.
  assign irq_en_nxt = ctrl_wr ? ~wb.wbs_dat_i[3] : irq_en_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irq_en_q <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_nxt;
      irq_q    <= irq_en_nxt & ((count_nxt != '0) | ovf_nxt);
    end
  end

  assign irq_o = irq_q;
`endif

  always_comb begin
    status              = '0;
    status[4 +: CNT_W]  = count_q;
`ifdef AES_RESULT_IRQ_EN
    status[3]           = irq_en_q;
`endif
    status[2]           = ovf_q;
    status[1]           = full_q;
    status[0]           = empty;
  end

  always_comb begin
    rdata = '0;
    case (word)
      3'd0:     rdata = empty ? 32'h0 : head[31:0];
      3'd1:     rdata = empty ? 32'h0 : head[63:32];
      3'd2:     rdata = empty ? 32'h0 : head[95:64];
      3'd3:     rdata = empty ? 32'h0 : head[127:96];
      W_STATUS: rdata = status;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      dat_q <= (accept & ~wb.wbs_we_i) ? rdata : 32'h0;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign full_o       = full_q;

endmodule

// File: tb/tb_aes_result_fifo.sv
// Directed bench for aes_result_fifo: read data checked by a monitor against
// an expected queue; side-band signals checked through a probe queue.
`timescale 1ns/1ps
module tb_aes_result_fifo;

  localparam logic [31:0] BASE = 32'h3000_0030;
  localparam logic [31:0] STAT = BASE + 32'd16;
  localparam logic [31:0] CTRL = BASE + 32'd20;
`ifdef AES_RESULT_IRQ_EN
  localparam logic [31:0] EN = 32'h8;
`else
  localparam logic [31:0] EN = 32'h0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ct_valid = 1'b0;
  logic [127:0] ct = '0;
  logic         full;
`ifdef AES_RESULT_IRQ_EN
  logic         irq;
`endif

  always #5 clk = ~clk;

  aes_result_fifo_if wb();

  aes_result_fifo #(
    .BASE_ADDRESS(BASE),
    .DEPTH(4),
    .CNT_W(5)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (wb.slave),
    .ct_valid_i (ct_valid),
    .ct_i       (ct),
    .full_o     (full)
`ifdef AES_RESULT_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef enum logic [2:0] {P_FULL, P_ACK, P_DAT, P_IRQ, P_TIMEOUT, P_QEMPTY} probe_e;
  typedef struct {
    probe_e      kind;
    logic [31:0] exp;
  } probe_t;

  logic [31:0] exp_q[$];
  probe_t      probe_q[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] mon_exp;
  logic [31:0] mon_act;
  probe_t      mon_p;

  always @(negedge clk) begin
    if (wb.wbs_ack_o && !wb.wbs_we_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got %08h, required no read ack", wb.wbs_dat_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (wb.wbs_dat_o !== mon_exp) begin
          fails++;
          $display("FAIL rd_data: got %08h, required %08h", wb.wbs_dat_o, mon_exp);
        end
      end
    end
    while (probe_q.size() != 0) begin
      mon_p = probe_q.pop_front();
      mon_act = '0;
      case (mon_p.kind)
        P_FULL:    mon_act = {31'b0, full};
        P_ACK:     mon_act = {31'b0, wb.wbs_ack_o};
        P_DAT:     mon_act = wb.wbs_dat_o;
`ifdef AES_RESULT_IRQ_EN
        P_IRQ:     mon_act = {31'b0, irq};
`endif
        P_TIMEOUT: mon_act = 32'h1;
        P_QEMPTY:  mon_act = exp_q.size();
        default:   mon_act = 32'hdead_beef;
      endcase
      checks++;
      if (mon_act !== mon_p.exp) begin
        fails++;
        $display("FAIL %s: got %08h, required %08h", mon_p.kind.name(), mon_act, mon_p.exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic probe(input probe_e k, input logic [31:0] e);
    probe_t p;
    p.kind = k;
    p.exp  = e;
    probe_q.push_back(p);
    @(negedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] data,
                         input logic push, input logic [127:0] pval);
    logic got;
    got = 1'b0;
    @(posedge clk); #2;
    wb.wbs_adr_i = addr;
    wb.wbs_we_i  = we;
    wb.wbs_dat_i = data;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    if (push) begin
      ct_valid = 1'b1;
      ct       = pval;
    end
    @(posedge clk); #2;
    ct_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (wb.wbs_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    if (!got) probe(P_TIMEOUT, 32'h0);
    probe(P_ACK, 32'h0);
  endtask

  task automatic wb_read(input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    wb_xfer(addr, 1'b0, 32'h0, 1'b0, '0);
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    wb_xfer(addr, 1'b1, data, 1'b0, '0);
  endtask

  task automatic push_ct(input logic [127:0] v);
    @(posedge clk); #2;
    ct_valid = 1'b1;
    ct       = v;
    @(posedge clk); #2;
    ct_valid = 1'b0;
  endtask

  task automatic pop_expect(input logic [31:0] head0);
    wb_read(BASE, head0);
    wb_write(CTRL, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset state
    probe(P_ACK, 32'h0);
    probe(P_DAT, 32'h0);
    probe(P_FULL, 32'h0);
`ifdef AES_RESULT_IRQ_EN
    probe(P_IRQ, 32'h0);
`endif
    wb_read(STAT, 32'h1 | EN);
    wb_read(BASE, 32'h0);
    wb_write(CTRL, 32'h1);               // pop while empty
    wb_read(STAT, 32'h1 | EN);

    // single ciphertext, word order
    push_ct(128'h00112233_44556677_8899AABB_CCDDEEFF);
    wb_read(BASE,         32'hCCDDEEFF);
    wb_read(BASE + 32'd4, 32'h8899AABB);
    wb_read(BASE + 32'd8, 32'h44556677);
    wb_read(BASE + 32'd12, 32'h00112233);
    wb_read(STAT, 32'h10 | EN);
    wb_write(CTRL, 32'h1);

    // fill, overflow, drain
    for (int v = 1; v <= 5; v++) push_ct(128'(v));
    wb_read(STAT, 32'h46 | EN);
    probe(P_FULL, 32'h1);
    for (int v = 1; v <= 4; v++) pop_expect(32'(v));
    wb_read(STAT, 32'h5 | EN);
    probe(P_FULL, 32'h0);
    wb_write(CTRL, 32'h2);
    wb_read(STAT, 32'h1 | EN);

    // pop and push on the same edge while full, pointers wrap
    for (int v = 1; v <= 4; v++) push_ct(128'(v));
    wb_xfer(CTRL, 1'b1, 32'h1, 1'b1, 128'd6);
    wb_read(STAT, 32'h42 | EN);
    pop_expect(32'd2);
    pop_expect(32'd3);
    pop_expect(32'd4);
    pop_expect(32'd6);
    wb_read(STAT, 32'h1 | EN);

    // overflow set and clear on the same edge: set wins
    for (int v = 7; v <= 10; v++) push_ct(128'(v));
    wb_xfer(CTRL, 1'b1, 32'h2, 1'b1, 128'd11);
    wb_read(STAT, 32'h46 | EN);
    wb_read(BASE, 32'd7);
    wb_write(BASE, 32'hFFFF_FFFF);       // read-only word
    wb_read(CTRL, 32'h0);                // CTRL reads as zero
    wb_read(STAT, 32'h46 | EN);

    // out-of-window access is never acked
    @(posedge clk); #2;
    wb.wbs_adr_i = BASE + 32'd64;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) probe(P_ACK, 32'h0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;

    // reset mid-transfer drops ack and clears the FIFO
    @(posedge clk); #2;
    wb.wbs_adr_i = STAT;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    probe(P_ACK, 32'h0);
    probe(P_FULL, 32'h0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    wb_read(STAT, 32'h1 | EN);

`ifdef AES_RESULT_IRQ_EN
    push_ct(128'd1);
    probe(P_IRQ, 32'h1);
    wb_write(CTRL, 32'h8);
    probe(P_IRQ, 32'h0);
    wb_read(STAT, 32'h10);
    wb_write(CTRL, 32'h1);
    probe(P_IRQ, 32'h0);
    wb_read(STAT, 32'h1 | EN);
`endif

    repeat (3) @(negedge clk);
    #1;
    probe(P_QEMPTY, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
